// File: rtl/gsram_pkg.sv
// Shared definitions for the gated-SRAM sweep controller.
//   ROWS_DEF / COLS_DEF / DW_DEF : default grid geometry and element width
//   ADDR_W                       : width of the row and column address buses
//   state_e                      : sweep FSM state encoding
//   is_gate_state()              : states in which the SRAM access enable is high
package gsram_pkg;

  localparam int ROWS_DEF = 10;
  localparam int COLS_DEF = 10;
  localparam int DW_DEF   = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RWAIT = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WRES  = 3'd4,
    ST_WR    = 3'd5,
    ST_ADV   = 3'd6,
    ST_FIN   = 3'd7
  } state_e;

  // The SRAM is only ever touched in the read-issue and write states.
  function automatic logic is_gate_state(input state_e s);
    return (s == ST_RD) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/grid_addr_counter.sv
// Row-major grid address counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force address to (0,0); wins over inc
//   inc       : step one cell; column wraps to 0 and row advances
//   row, col  : current (registered) cell address
//   wrap      : column is at COLS-1 (next inc wraps the column)
//   last      : row is at ROWS-1 (together with wrap marks the final cell)
module grid_addr_counter
  import gsram_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              wrap,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(COLS - 1);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;

  assign wrap = (col_q == COL_MAX);
  assign last = (row_q == ROW_MAX);
  assign row  = row_q;
  assign col  = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (wrap) begin
        col_d = '0;
        // The controller never steps past the final cell, but keep the
        // row inside the grid regardless.
        row_d = last ? '0 : row_q + 4'd1;
      end else begin
        col_d = col_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/gsram_sweep_ctrl.sv
// Sweep controller for a gated SRAM grid: reads every cell in row-major
// order, hands the value to an external compute unit, waits for the result
// and writes it back to the same cell.
//   clk, rst        : clock, synchronous active-high reset
//   start, mode     : begin a sweep (IDLE only); mode 0 = multiplier, 1 = LUT
//   abort           : end the running sweep early
//   gate, we        : SRAM access enable / write enable
//   row, col        : SRAM cell address
//   inmuxsel        : SRAM write-data source select
//   rdata           : SRAM read data
//   op_data/op_valid/op_ready : operand handshake towards the compute unit
//   res_valid       : compute result is stable at the SRAM data input
//   busy, done      : not idle / one-cycle end-of-sweep pulse
//   aborted         : sticky "last sweep was aborted", cleared by start
module gsram_sweep_ctrl
  import gsram_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          abort,
  output logic          gate,
  output logic          we,
  output logic [3:0]    row,
  output logic [3:0]    col,
  output logic          inmuxsel,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] op_data,
  output logic          op_valid,
  input  logic          op_ready,
  input  logic          res_valid,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic            aborted_q, aborted_d;
  logic [DW-1:0]   op_data_q, op_data_d;

  logic            gate_q, we_q, inmuxsel_q, op_valid_q, busy_q, done_q;

  logic            cnt_clr, cnt_inc, cnt_wrap, cnt_last;
  logic [ADDR_W-1:0] cnt_row, cnt_col;

  grid_addr_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .row  (cnt_row),
    .col  (cnt_col),
    .wrap (cnt_wrap),
    .last (cnt_last)
  );

  // Next-state logic. Abort is honoured in every state that has not yet
  // committed to a write; once in WR the write is allowed to complete.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    aborted_d = aborted_q;
    op_data_d = op_data_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RD;
          cnt_clr   = 1'b1;
          mode_d    = mode;
          aborted_d = 1'b0;
        end
      end
      ST_RD: begin
        if (abort) begin
          state_d   = ST_FIN;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (abort) begin
          state_d   = ST_FIN;
          aborted_d = 1'b1;
        end else begin
          // SRAM registered its output at the end of RD; take it now.
          op_data_d = rdata;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d   = ST_FIN;
          aborted_d = 1'b1;
        end else if (op_ready) begin
          state_d = ST_WRES;
        end
      end
      ST_WRES: begin
        if (abort) begin
          state_d   = ST_FIN;
          aborted_d = 1'b1;
        end else if (res_valid) begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (abort) begin
          state_d   = ST_FIN;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_ADV;
        end
      end
      ST_ADV: begin
        // Address still points at the cell just written.
        if (cnt_wrap && cnt_last) begin
          state_d = ST_FIN;
        end else begin
          cnt_inc = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state and line up with it cycle for cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      aborted_q  <= 1'b0;
      op_data_q  <= '0;
      gate_q     <= 1'b0;
      we_q       <= 1'b0;
      inmuxsel_q <= 1'b0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      aborted_q  <= aborted_d;
      op_data_q  <= op_data_d;
      gate_q     <= is_gate_state(state_d);
      we_q       <= (state_d == ST_WR);
      inmuxsel_q <= ((state_d == ST_WRES) || (state_d == ST_WR)) ? mode_d : 1'b0;
      op_valid_q <= (state_d == ST_ISSUE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FIN);
    end
  end

  assign gate     = gate_q;
  assign we       = we_q;
  assign row      = cnt_row;
  assign col      = cnt_col;
  assign inmuxsel = inmuxsel_q;
  assign op_data  = op_data_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_gsram_sweep_ctrl.sv
// Bench for gsram_sweep_ctrl: SRAM model, compute-unit model (x+1 or LUT),
// and a write scoreboard filled when each sweep is launched.
module tb_gsram_sweep_ctrl;

  localparam int ROWS      = 10;
  localparam int COLS      = 10;
  localparam int DW        = 16;
  localparam int CYC_LIMIT = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, mode, abort, op_ready;
  logic          res_valid = 1'b0;
  logic          gate, we, inmuxsel, op_valid, busy, done, aborted;
  logic [3:0]    row, col;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] op_data;
  logic [DW-1:0] res_m2 = '0;
  logic [DW-1:0] res_lut = '0;

  gsram_sweep_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .gate(gate), .we(we), .row(row), .col(col), .inmuxsel(inmuxsel),
    .rdata(rdata), .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
    .res_valid(res_valid), .busy(busy), .done(done), .aborted(aborted)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem      [ROWS][COLS];
  logic [DW-1:0] init_pat [ROWS][COLS];
  logic [DW-1:0] exp_mem  [ROWS][COLS];
  logic          init_en = 1'b0;

  typedef struct {
    int            r;
    int            c;
    logic [DW-1:0] d;
    logic          sel;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  wr_exp_t mon_e;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;

  function automatic logic [DW-1:0] lut_fn(input logic [DW-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A3C;
  endfunction

  // SRAM: registered read, write on gate&we.
  always @(posedge clk) begin
    if (init_en) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem[r][c] <= init_pat[r][c];
    end else if (gate) begin
      if (we) mem[row][col] <= inmuxsel ? res_lut : res_m2;
      else    rdata <= mem[row][col];
    end
  end

  // Compute unit: result valid one cycle after the handshake, held until written.
  always @(posedge clk) begin
    if (rst || done) res_valid <= 1'b0;
    else if (op_valid && op_ready) begin
      res_valid <= 1'b1;
      res_m2    <= op_data + 16'd1;
      res_lut   <= lut_fn(op_data);
    end else if (gate && we) res_valid <= 1'b0;
  end

  // Write scoreboard and bus monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (gate && !we) rd_cnt++;
      if (we) begin
        wr_cnt++;
        checks++;
        if (!gate) begin
          errors++;
          $display("FAIL we_gate: gate=%0b we=%0b, required gate=1 with we", gate, we);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got write at (%0d,%0d), required none", row, col);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(row) != mon_e.r || int'(col) != mon_e.c || inmuxsel !== mon_e.sel ||
              (inmuxsel ? res_lut : res_m2) !== mon_e.d) begin
            errors++;
            $display("FAIL write: got (%0d,%0d) sel=%0b data=%h, required (%0d,%0d) sel=%0b data=%h",
                     row, col, inmuxsel, inmuxsel ? res_lut : res_m2,
                     mon_e.r, mon_e.c, mon_e.sel, mon_e.d);
          end else begin
            $display("WR (%0d,%0d) sel=%0b data=%h", row, col, inmuxsel, mon_e.d);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic load_mem();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        init_pat[r][c] = DW'($urandom);
        exp_mem[r][c]  = init_pat[r][c];
      end
    @(negedge clk); init_en = 1'b1;
    @(negedge clk); init_en = 1'b0;
  endtask

  task automatic push_sweep(input logic sel, input int ncells);
    wr_exp_t e;
    for (int i = 0; i < ncells; i++) begin
      e.r   = i / COLS;
      e.c   = i % COLS;
      e.sel = sel;
      e.d   = sel ? lut_fn(exp_mem[e.r][e.c]) : exp_mem[e.r][e.c] + 16'd1;
      exp_mem[e.r][e.c] = e.d;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < CYC_LIMIT; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gate, we, op_valid, done, busy, aborted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 000000", {gate, we, op_valid, done, busy, aborted});
    end
    checks++;
    if ({row, col, inmuxsel} !== 9'b0 || op_data !== '0) begin
      errors++;
      $display("FAIL reset_addr: got row=%0d col=%0d sel=%0b op=%h, required 0", row, col, inmuxsel, op_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_sweep(input logic sel);
    bit ok; int b_wr, b_rd, b_done, mism;
    load_mem();
    b_wr = wr_cnt; b_rd = rd_cnt; b_done = done_cnt;
    push_sweep(sel, ROWS * COLS);
    pulse_start(sel);
    checks++;
    if (row !== 4'd0 || col !== 4'd0 || gate !== 1'b1 || we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep%0d_first_rd: got (%0d,%0d) gate=%0b we=%0b busy=%0b, required (0,0) 1 0 1",
               sel, row, col, gate, we, busy);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sweep%0d_done_timeout: no done in %0d cycles", sel, CYC_LIMIT); end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - b_done != 1 || wr_cnt - b_wr != ROWS * COLS || rd_cnt - b_rd != ROWS * COLS) begin
      errors++;
      $display("FAIL sweep%0d_counts: got done=%0d wr=%0d rd=%0d, required 1 100 100",
               sel, done_cnt - b_done, wr_cnt - b_wr, rd_cnt - b_rd);
    end
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep%0d_end: got busy=%0b aborted=%0b pending=%0d, required 0 0 0",
               sel, busy, aborted, exp_q.size());
    end
    mism = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (mem[r][c] !== exp_mem[r][c]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL sweep%0d_mem: %0d cells differ, required 0", sel, mism); end
  endtask

  task automatic test_stall();
    bit ok, found; int mism; logic [DW-1:0] old37;
    load_mem();
    old37 = exp_mem[3][7];
    push_sweep(1'b0, ROWS * COLS);
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < CYC_LIMIT; i++) begin
      @(negedge clk);
      if (op_valid && row == 4'd3 && col == 4'd7) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_reach: never saw op_valid at (3,7)"); end
    op_ready = 1'b0;
    checks++;
    if (op_data !== old37) begin
      errors++; $display("FAIL stall_operand: got %h, required %h", op_data, old37);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (op_valid !== 1'b1 || op_data !== old37 || row !== 4'd3 || col !== 4'd7) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%0b op=%h (%0d,%0d), required 1 %h (3,7)",
                 k, op_valid, op_data, row, col, old37);
      end
    end
    op_ready = 1'b1;
    wait_done(ok);
    repeat (2) @(negedge clk);
    mism = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (mem[r][c] !== exp_mem[r][c]) mism++;
    checks++;
    if (!ok || mism != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_end: got done=%0b mism=%0d pending=%0d, required 1 0 0", ok, mism, exp_q.size());
    end
  endtask

  task automatic test_abort();
    bit ok, found; int mism, b_done;
    load_mem();
    b_done = done_cnt;
    push_sweep(1'b0, 2 * COLS + 4);
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < CYC_LIMIT; i++) begin
      @(negedge clk);
      // WRES: busy, bus idle, no operand pending, result already presented.
      if (row == 4'd2 && col == 4'd4 && busy && !gate && !op_valid && res_valid) begin
        found = 1'b1; break;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!found || done !== 1'b1 || aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_fin: got found=%0b done=%0b aborted=%0b, required 1 1 1", found, done, aborted);
    end
    wait_done(ok);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - b_done != 1 || aborted !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_end: got done=%0d aborted=%0b busy=%0b pending=%0d, required 1 1 0 0",
               done_cnt - b_done, aborted, busy, exp_q.size());
    end
    mism = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (mem[r][c] !== exp_mem[r][c]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL abort_mem: %0d cells differ, required 0", mism); end
  endtask

  task automatic test_start_ignored_and_rst();
    bit found, pulsed; int b_wr, mism;
    load_mem();
    push_sweep(1'b0, 5 * COLS);
    pulse_start(1'b0);
    found = 1'b0; pulsed = 1'b0;
    for (int i = 0; i < CYC_LIMIT; i++) begin
      @(negedge clk);
      start = (!pulsed && row == 4'd1 && col == 4'd3 && gate && !we);
      if (start) pulsed = 1'b1;
      if (row == 4'd5 && col == 4'd0) begin found = 1'b1; break; end
    end
    start = 1'b0;
    rst = 1'b1;
    b_wr = wr_cnt;
    repeat (2) @(negedge clk);
    checks++;
    if (!found || {gate, we, op_valid, done, busy, aborted} !== 6'b0) begin
      errors++;
      $display("FAIL rst_ctrl: got found=%0b ctrl=%b, required 1 000000",
               found, {gate, we, op_valid, done, busy, aborted});
    end
    checks++;
    if ({row, col, inmuxsel} !== 9'b0 || op_data !== '0) begin
      errors++;
      $display("FAIL rst_addr: got row=%0d col=%0d sel=%0b op=%h, required 0", row, col, inmuxsel, op_data);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    mism = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (mem[r][c] !== exp_mem[r][c]) mism++;
    checks++;
    if (wr_cnt != b_wr || busy !== 1'b0 || exp_q.size() != 0 || mism != 0) begin
      errors++;
      $display("FAIL rst_after: got extra_wr=%0d busy=%0b pending=%0d mism=%0d, required 0 0 0 0",
               wr_cnt - b_wr, busy, exp_q.size(), mism);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, found; int mism, b_done;
    load_mem();
    b_done = done_cnt;
    push_sweep(1'b0, COLS);
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < CYC_LIMIT; i++) begin
      @(negedge clk);
      if (row == 4'd1 && col == 4'd0 && gate && !we) begin found = 1'b1; break; end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!found || done !== 1'b1 || aborted !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got found=%0b done=%0b aborted=%0b, required 1 1 1", found, done, aborted);
    end
    @(negedge clk);
    push_sweep(1'b1, ROWS * COLS);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (row !== 4'd0 || col !== 4'd0 || gate !== 1'b1 || aborted !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got (%0d,%0d) gate=%0b aborted=%0b busy=%0b, required (0,0) 1 0 1",
               row, col, gate, aborted, busy);
    end
    wait_done(ok);
    repeat (3) @(negedge clk);
    mism = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) if (mem[r][c] !== exp_mem[r][c]) mism++;
    checks++;
    if (!ok || done_cnt - b_done != 2 || aborted !== 1'b0 || exp_q.size() != 0 || mism != 0) begin
      errors++;
      $display("FAIL b2b_end: got ok=%0b done=%0d aborted=%0b pending=%0d mism=%0d, required 1 2 0 0 0",
               ok, done_cnt - b_done, aborted, exp_q.size(), mism);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; op_ready = 1'b1;
    test_reset();
    test_full_sweep(1'b0);
    test_full_sweep(1'b1);
    test_stall();
    test_abort();
    test_start_ignored_and_rst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
